// File: rtl/material_evaluator.sv
// material_evaluator: scans board RAM LANES squares per cycle and produces a saturated, overridable material score.
module material_evaluator #(
  parameter int SQUARES = 64,
  parameter int LANES = 1,
  parameter int SCORE_W = 16,
  parameter int WEIGHT_W = 8,
  parameter logic [6*WEIGHT_W-1:0] PIECE_WEIGHTS = {8'd0, 8'd9, 8'd5, 8'd3, 8'd3, 8'd1},
  parameter logic signed [SCORE_W-1:0] MATE_SCORE = 16'sd30000,
  parameter bit RELATIVE = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [1:0]                        checkmate,
  input  logic                              stalemate,
  input  logic                              white_to_move,
  output logic                              rd_en,
  output logic [$clog2(SQUARES/LANES)-1:0]  rd_addr,
  input  logic [4*LANES-1:0]                rd_data,
  output logic                              busy,
  output logic                              done,
  output logic signed [SCORE_W-1:0]         score,
  output logic                              bad_piece
);
  localparam int G = SQUARES / LANES;
  localparam int AW = $clog2(G);
  localparam int ACC_W = SCORE_W + 8;
  localparam logic signed [ACC_W-1:0] LIM = ACC_W'(MATE_SCORE) - ACC_W'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINAL} state_t;

  state_t state, state_n;
  logic vld, bad_acc, lane_bad, bad_n, sm_q, wtm_q;
  logic [1:0] cm_q;
  logic signed [ACC_W-1:0] acc, acc_n, lane_sum, sat;
  logic signed [SCORE_W-1:0] ovr, fin;

  function automatic logic signed [ACC_W-1:0] weigh(input logic [3:0] code);
    logic [2:0] t;
    int idx;
    logic signed [ACC_W-1:0] w;
    t = code[2:0];
    idx = (t == 3'd0 || t == 3'd7) ? 0 : int'(t) - 1;
    w = (t == 3'd0 || t == 3'd7) ? '0 : ACC_W'(PIECE_WEIGHTS[idx*WEIGHT_W +: WEIGHT_W]);
    return code[3] ? -w : w;
  endfunction

  assign busy = state == ISSUE || state == DRAIN;
  assign rd_en = state == ISSUE;
  assign done = state == FINAL;

  always_comb begin
    lane_sum = '0;
    lane_bad = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      lane_sum = lane_sum + weigh(rd_data[4*j +: 4]);
      lane_bad = lane_bad | (rd_data[4*j +: 3] == 3'd7);
    end
    acc_n = vld ? acc + lane_sum : acc;
    bad_n = bad_acc | (vld & lane_bad);
    sat = acc_n > LIM ? LIM : (acc_n < -LIM ? -LIM : acc_n);
    // Overrides sit on top of saturation; perspective flip comes last so it also flips mate scores
    ovr = (&cm_q || sm_q) ? '0 : (cm_q[1] ? -MATE_SCORE : (cm_q[0] ? MATE_SCORE : sat[SCORE_W-1:0]));
    fin = (RELATIVE && !wtm_q) ? -ovr : ovr;
    state_n = state == IDLE ? (start ? ISSUE : IDLE) :
              state == ISSUE ? (rd_addr == AW'(G - 1) ? DRAIN : ISSUE) :
              state == DRAIN ? FINAL : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_addr <= '0;
      vld <= 1'b0;
      acc <= '0;
      bad_acc <= 1'b0;
      score <= '0;
      bad_piece <= 1'b0;
      cm_q <= '0;
      sm_q <= 1'b0;
      wtm_q <= 1'b0;
    end else begin
      state <= state_n;
      vld <= rd_en;
      if (state == IDLE && start) begin
        cm_q <= checkmate;
        sm_q <= stalemate;
        wtm_q <= white_to_move;
        acc <= '0;
        bad_acc <= 1'b0;
        rd_addr <= '0;
      end else begin
        acc <= acc_n;
        bad_acc <= bad_n;
        if (rd_en) rd_addr <= rd_addr + 1'b1;
      end
      if (state == DRAIN) begin
        score <= fin;
        bad_piece <= bad_n;
      end
    end
  end
endmodule

// File: tb/tb_material_evaluator.sv
// tb_material_evaluator: three evaluator configurations checked against a board-level scoring model.
module tb_material_evaluator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0, start_bc = 1'b0;
  logic [1:0] checkmate = '0;
  logic stalemate = 1'b0, white_to_move = 1'b1;
  logic armed = 1'b0;
  logic [3:0] board[64];
  logic [3:0] rd_a;
  logic [15:0] rd_b, rd_c;
  logic [5:0] addr_a;
  logic [3:0] addr_b, addr_c;
  logic [5:0] addr_v[3];
  logic busy_v[3], done_v[3], rd_en_v[3], bad_v[3];
  logic signed [15:0] score_v[3];
  int cyc = 0;
  int checks = 0, errors = 0;
  int t_acc[3] = '{-1000, -1000, -1000};
  int free[3] = '{0, 0, 0};
  int held[3] = '{0, 0, 0};
  int pend[3] = '{0, 0, 0};
  bit hbad[3] = '{0, 0, 0};
  bit pbad[3] = '{0, 0, 0};
  int gg[3] = '{64, 16, 16};
  int qs[3] = '{9, 255, 1000};
  bit rels[3] = '{1, 0, 0};

  always #5 clk = ~clk;

  material_evaluator #(.LANES(1), .RELATIVE(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .checkmate(checkmate), .stalemate(stalemate),
    .white_to_move(white_to_move), .rd_en(rd_en_v[0]), .rd_addr(addr_a), .rd_data(rd_a),
    .busy(busy_v[0]), .done(done_v[0]), .score(score_v[0]), .bad_piece(bad_v[0]));

  material_evaluator #(.LANES(4), .PIECE_WEIGHTS({8'd0, 8'd255, 8'd5, 8'd3, 8'd3, 8'd1})) dut_b (
    .clk(clk), .rst(rst), .start(start_bc), .checkmate(checkmate), .stalemate(stalemate),
    .white_to_move(white_to_move), .rd_en(rd_en_v[1]), .rd_addr(addr_b), .rd_data(rd_b),
    .busy(busy_v[1]), .done(done_v[1]), .score(score_v[1]), .bad_piece(bad_v[1]));

  material_evaluator #(.LANES(4), .WEIGHT_W(10),
    .PIECE_WEIGHTS({10'd0, 10'd1000, 10'd5, 10'd3, 10'd3, 10'd1})) dut_c (
    .clk(clk), .rst(rst), .start(start_bc), .checkmate(checkmate), .stalemate(stalemate),
    .white_to_move(white_to_move), .rd_en(rd_en_v[2]), .rd_addr(addr_c), .rd_data(rd_c),
    .busy(busy_v[2]), .done(done_v[2]), .score(score_v[2]), .bad_piece(bad_v[2]));

  assign addr_v[0] = addr_a;
  assign addr_v[1] = {2'b0, addr_b};
  assign addr_v[2] = {2'b0, addr_c};

  always @(posedge clk) begin
    rd_a <= board[addr_a];
    for (int j = 0; j < 4; j++) begin
      rd_b[4*j +: 4] <= board[4*int'(addr_b) + j];
      rd_c[4*j +: 4] <= board[4*int'(addr_c) + j];
    end
  end

  function automatic int model_score(input int q, input bit rel, input logic [1:0] cm,
                                     input logic sm, input logic wtm);
    int w[8];
    int raw;
    w = '{0, 1, 3, 3, 5, q, 0, 0};
    raw = 0;
    for (int i = 0; i < 64; i++) raw += board[i][3] ? -w[board[i][2:0]] : w[board[i][2:0]];
    if (raw > 29999) raw = 29999;
    if (raw < -29999) raw = -29999;
    if (cm == 2'b11 || sm) raw = 0;
    else if (cm == 2'b10) raw = -30000;
    else if (cm == 2'b01) raw = 30000;
    return (rel && !wtm) ? -raw : raw;
  endfunction

  function automatic bit model_bad();
    bit b;
    b = 0;
    for (int i = 0; i < 64; i++) if (board[i][2:0] == 3'd7) b = 1;
    return b;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        t_acc[d] <= -1000;
        free[d] <= 0;
        held[d] <= 0;
        hbad[d] <= 0;
      end else begin
        if (cyc == t_acc[d] + gg[d] + 1) begin
          held[d] <= pend[d];
          hbad[d] <= pbad[d];
        end
        if ((d == 0 ? start_a : start_bc) && cyc >= free[d]) begin
          t_acc[d] <= cyc;
          free[d] <= cyc + gg[d] + 3;
          pend[d] <= model_score(qs[d], rels[d], checkmate, stalemate, white_to_move);
          pbad[d] <= model_bad();
        end
      end
    end
  end

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int t, g;
    if (armed) begin
      for (int d = 0; d < 3; d++) begin
        t = t_acc[d];
        g = gg[d];
        chk($sformatf("busy%0d", d), busy_v[d], cyc > t && cyc <= t + g + 1);
        chk($sformatf("rd_en%0d", d), rd_en_v[d], cyc > t && cyc <= t + g);
        chk($sformatf("done%0d", d), done_v[d], cyc == t + g + 2);
        chk($sformatf("score%0d", d), score_v[d], held[d]);
        chk($sformatf("bad%0d", d), bad_v[d], hbad[d]);
        if (cyc > t && cyc <= t + g) chk($sformatf("rd_addr%0d", d), addr_v[d], cyc - t - 1);
      end
    end
  end

  task automatic go(input int d, input logic [1:0] cm, input logic sm, input logic wtm, output int t0);
    @(negedge clk);
    checkmate = cm;
    stalemate = sm;
    white_to_move = wtm;
    if (d == 0) start_a = 1'b1;
    else start_bc = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_a = 1'b0;
    start_bc = 1'b0;
    checkmate = ~cm;
    stalemate = ~sm;
    white_to_move = ~wtm;
  endtask

  task automatic wait_done(input int d, input int t0, output int lat, output int reads);
    lat = -1;
    reads = 0;
    for (int i = 0; i < 200 && lat < 0; i++) begin
      if (rd_en_v[d]) reads++;
      if (done_v[d]) lat = cyc - t0;
      else @(negedge clk);
    end
  endtask

  task automatic eval_a(input string nm, input logic [1:0] cm, input logic sm, input logic wtm,
                        input int exp_s, input bit exp_b);
    int t0, lat, r;
    go(0, cm, sm, wtm, t0);
    wait_done(0, t0, lat, r);
    chk({nm, "_lat"}, lat, 66);
    chk({nm, "_score"}, score_v[0], exp_s);
    chk({nm, "_bad"}, bad_v[0], exp_b);
  endtask

  task automatic eval_bc(input string nm, input int exp_b, input int exp_c);
    int t0, lat, r;
    go(1, 2'b00, 1'b0, 1'b1, t0);
    wait_done(1, t0, lat, r);
    chk({nm, "_lat"}, lat, 18);
    chk({nm, "_reads"}, r, 16);
    chk({nm, "_score_b"}, score_v[1], exp_b);
    chk({nm, "_score_c"}, score_v[2], exp_c);
  endtask

  task automatic set_initial();
    logic [3:0] back[8];
    back = '{4'd4, 4'd2, 4'd3, 4'd5, 4'd6, 4'd3, 4'd2, 4'd4};
    for (int i = 0; i < 64; i++) board[i] = 4'd0;
    for (int i = 0; i < 8; i++) begin
      board[i] = back[i];
      board[8+i] = 4'd1;
      board[48+i] = 4'd9;
      board[56+i] = back[i] | 4'd8;
    end
  endtask

  initial begin
    int t0, lat, r, n;
    for (int i = 0; i < 64; i++) board[i] = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    armed = 1'b1;
    chk("rst_busy", busy_v[0], 0);
    chk("rst_done", done_v[0], 0);
    chk("rst_rd_en", rd_en_v[0], 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_score", score_v[0], 0);
    chk("rst_bad", bad_v[0], 0);
    while (cyc != 9) @(negedge clk);
    go(0, 2'b00, 1'b0, 1'b1, t0);
    wait_done(0, t0, lat, r);
    chk("empty_start_cyc", t0, 10);
    chk("empty_done_cyc", t0 + lat, 76);
    chk("empty_reads", r, 64);
    chk("empty_score", score_v[0], 0);
    chk("empty_bad", bad_v[0], 0);
    set_initial();
    eval_a("init", 2'b00, 1'b0, 1'b1, 0, 0);
    board[59] = 4'd0;
    eval_a("no_bq", 2'b00, 1'b0, 1'b1, 9, 0);
    board[8] = 4'd0;
    eval_a("no_wp", 2'b00, 1'b0, 1'b1, 8, 0);
    board[8] = 4'd1;
    eval_a("rel", 2'b00, 1'b0, 1'b0, -9, 0);
    eval_a("rel_mate", 2'b01, 1'b0, 1'b0, -30000, 0);
    eval_a("w_mated", 2'b10, 1'b0, 1'b1, -30000, 0);
    eval_a("stale", 2'b00, 1'b1, 1'b1, 0, 0);
    eval_a("both_mated", 2'b11, 1'b0, 1'b1, 0, 0);
    board[5] = 4'b0111;
    eval_a("reserved", 2'b00, 1'b0, 1'b1, 6, 1);
    board[5] = 4'd3;
    eval_a("clean", 2'b00, 1'b0, 1'b1, 9, 0);
    go(0, 2'b00, 1'b0, 1'b1, t0);
    repeat (19) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, t0, lat, r);
    chk("midstart_lat", lat, 66);
    chk("midstart_score", score_v[0], 9);
    go(0, 2'b00, 1'b0, 1'b1, t0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy_v[0], 0);
    chk("abort_score", score_v[0], 0);
    n = 0;
    repeat (80) begin
      @(negedge clk);
      if (done_v[0]) n++;
    end
    chk("abort_no_done", n, 0);
    for (int i = 0; i < 64; i++) board[i] = 4'd5;
    eval_bc("wq", 16320, 29999);
    for (int i = 0; i < 64; i++) board[i] = (i < 16) ? 4'd13 : 4'd0;
    eval_bc("bq", -4080, -16000);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got running want finished", cyc);
    $fatal(1, "watchdog");
  end
endmodule
